// File: rtl/sym_err_pkg.sv
// Shared widths, saturation limits and sign helper for the symbol-sync error detector.
package sym_err_pkg;

  typedef enum logic {
    SGN_POS = 1'b0,
    SGN_NEG = 1'b1
  } sgn_e;

  // Difference width for one sample pair
  function automatic int unsigned dw(input int unsigned w);
    return w + 1;
  endfunction

  // Width of the full timing-error sum
  function automatic int unsigned tw(input int unsigned w);
    return 2 * w + 2;
  endfunction

  // Saturation bound of an aw-bit signed accumulator, in the low aw bits
  function automatic logic [63:0] sat_lim(input int unsigned aw, input logic neg);
    logic [63:0] mag;
    mag = (64'd1 << (aw - 1)) - 64'd1;
    return neg ? ~mag : mag;
  endfunction

  // Zero counts as positive
  function automatic sgn_e sgn_of(input logic msb);
    return msb ? SGN_NEG : SGN_POS;
  endfunction

endpackage

// File: rtl/sym_err_det_if.sv
// Sample-in / error-out bus of sym_err_det.
interface sym_err_det_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 24
);
  logic [W-1:0]  dix;
  logic [W-1:0]  diy;
  logic          iv;
  logic          fv;
  logic [W-1:0]  dox;
  logic [W-1:0]  doy;
  logic          sv;
  logic          slip;
  logic [AW-1:0] ferr;
  logic [AW-1:0] terr;
  logic          ovf;
  logic          ev;

  modport master (
    output dix, diy, iv, fv,
    input  dox, doy, sv, slip, ferr, terr, ovf, ev
  );

  modport slave (
    input  dix, diy, iv, fv,
    output dox, doy, sv, slip, ferr, terr, ovf, ev
  );
endinterface

// File: rtl/sym_err_det_sat_acc.sv
// Saturating signed accumulator with load/add and a sticky overflow flag.
module sat_acc
  import sym_err_pkg::*;
#(
  parameter int unsigned AW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [AW-1:0] din_i,
  output logic [AW-1:0] sum_o,
  output logic          ovf_o
);
  localparam logic [AW-1:0] SAT_POS = AW'(sat_lim(AW, 1'b0));
  localparam logic [AW-1:0] SAT_NEG = AW'(sat_lim(AW, 1'b1));

  logic [AW-1:0] acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   base;
  logic [AW:0]   raw;
  logic          sat;

  always_comb begin
    base  = load_i ? '0 : {acc_q[AW-1], acc_q};
    raw   = base + {din_i[AW-1], din_i};
    // One guard bit suffices: the two top bits disagree only on overflow
    sat   = raw[AW] ^ raw[AW-1];
    acc_d = raw[AW-1:0];
    if (sat) begin
      acc_d = raw[AW] ? SAT_NEG : SAT_POS;
    end
    ovf_d = (load_i ? 1'b0 : ovf_q) | sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o = acc_d;
  assign ovf_o = ovf_d;

endmodule

// File: rtl/sym_err_det.sv
// Symbol-sync error detector: Gardner timing and Costas carrier error, block-accumulated.
// Build option: define SYM_ERR_QPSK_EN for the QPSK carrier detector (BPSK otherwise).
module sym_err_det
  import sym_err_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned AW        = 24,
  parameter int unsigned NSYM_LOG2 = 4
) (
  input logic          clk,
  input logic          rst,
  sym_err_det_if.slave bus
);
  localparam int unsigned DW = dw(W);
  localparam int unsigned TW = tw(W);
  localparam int unsigned PW = TW - 1;

  // ---------------- history and symbol qualification ----------------
  logic [W-1:0] x2_q, y2_q, x1_q, y1_q;
  logic [1:0]   gap_q, gap_d;
  logic         seen_q;
  logic         fv_smp, sym_ok, sym_slip;

  always_comb begin
    fv_smp   = bus.iv & bus.fv;
    sym_ok   = fv_smp & seen_q & (gap_q == 2'd1);
    sym_slip = fv_smp & seen_q & ~sym_ok;
    gap_d    = gap_q;
    if (bus.iv) begin
      if (bus.fv) begin
        gap_d = '0;
      end else if (gap_q != 2'd2) begin
        gap_d = gap_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x2_q   <= '0;
      y2_q   <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      gap_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      if (bus.iv) begin
        if (bus.fv) begin
          x2_q   <= bus.dix;
          y2_q   <= bus.diy;
          seen_q <= 1'b1;
        end else begin
          x1_q <= bus.dix;
          y1_q <= bus.diy;
        end
      end
    end
  end

  // ---------------- S1: window and differences ----------------
  logic          s1_v_q, s1_slip_q;
  logic [W-1:0]  s1_x0_q, s1_y0_q, s1_x1_q, s1_y1_q;
  logic [DW-1:0] s1_dx_q, s1_dy_q, dx_d, dy_d;

  always_comb begin
    dx_d = DW'($signed(x2_q)) - DW'($signed(bus.dix));
    dy_d = DW'($signed(y2_q)) - DW'($signed(bus.diy));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_slip_q <= 1'b0;
      s1_x0_q   <= '0;
      s1_y0_q   <= '0;
      s1_x1_q   <= '0;
      s1_y1_q   <= '0;
      s1_dx_q   <= '0;
      s1_dy_q   <= '0;
    end else begin
      s1_v_q    <= sym_ok;
      s1_slip_q <= sym_slip;
      if (sym_ok) begin
        s1_x0_q <= bus.dix;
        s1_y0_q <= bus.diy;
        s1_x1_q <= x1_q;
        s1_y1_q <= y1_q;
        s1_dx_q <= dx_d;
        s1_dy_q <= dy_d;
      end
    end
  end

  // ---------------- S2: products ----------------
  logic          s2_v_q;
  logic [PW-1:0] s2_px_q, s2_py_q, px_d, py_d;
  logic [AW-1:0] s2_fe_q, fe_d;
`ifdef SYM_ERR_QPSK_EN
  logic [W:0]    fe_ya, fe_xb;
  logic [W+1:0]  fe_n;
`else
  logic [2*W-1:0] fe_n;
`endif

  always_comb begin
    px_d = PW'($signed(s1_dx_q)) * PW'($signed(s1_x1_q));
    py_d = PW'($signed(s1_dy_q)) * PW'($signed(s1_y1_q));
`ifdef SYM_ERR_QPSK_EN
    fe_ya = DW'($signed(s1_y0_q));
    fe_xb = DW'($signed(s1_x0_q));
    if (sgn_of(s1_x0_q[W-1]) == SGN_NEG) fe_ya = -fe_ya;
    if (sgn_of(s1_y0_q[W-1]) == SGN_NEG) fe_xb = -fe_xb;
    fe_n = (W+2)'($signed(fe_ya)) - (W+2)'($signed(fe_xb));
`else
    fe_n = (2*W)'($signed(s1_x0_q)) * (2*W)'($signed(s1_y0_q));
`endif
    fe_d = AW'($signed(fe_n));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q  <= 1'b0;
      s2_px_q <= '0;
      s2_py_q <= '0;
      s2_fe_q <= '0;
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_px_q <= px_d;
        s2_py_q <= py_d;
        s2_fe_q <= fe_d;
      end
    end
  end

  // ---------------- S3: block accumulation ----------------
  logic [TW-1:0]        te_n;
  logic [AW-1:0]        te_d;
  logic [NSYM_LOG2-1:0] nsym_q;
  logic                 blk_first, blk_last;
  logic [AW-1:0]        fsum, tsum;
  logic                 fovf, tovf;
  logic [AW-1:0]        ferr_q, terr_q;
  logic                 ovf_q, ev_q;

  always_comb begin
    te_n      = TW'($signed(s2_px_q)) + TW'($signed(s2_py_q));
    te_d      = AW'($signed(te_n));
    blk_first = (nsym_q == '0);
    blk_last  = (nsym_q == '1);
  end

  sat_acc #(.AW(AW)) u_facc (
    .clk    (clk),
    .rst    (rst),
    .en_i   (s2_v_q),
    .load_i (blk_first),
    .din_i  (s2_fe_q),
    .sum_o  (fsum),
    .ovf_o  (fovf)
  );

  sat_acc #(.AW(AW)) u_tacc (
    .clk    (clk),
    .rst    (rst),
    .en_i   (s2_v_q),
    .load_i (blk_first),
    .din_i  (te_d),
    .sum_o  (tsum),
    .ovf_o  (tovf)
  );

  // Outputs take the accumulators' next value so ev lands in the same cycle as the last add
  always_ff @(posedge clk) begin
    if (rst) begin
      nsym_q <= '0;
      ferr_q <= '0;
      terr_q <= '0;
      ovf_q  <= 1'b0;
      ev_q   <= 1'b0;
    end else begin
      ev_q <= 1'b0;
      if (s2_v_q) begin
        nsym_q <= nsym_q + NSYM_LOG2'(1);
        if (blk_last) begin
          ferr_q <= fsum;
          terr_q <= tsum;
          ovf_q  <= fovf | tovf;
          ev_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.dox  = s1_x0_q;
  assign bus.doy  = s1_y0_q;
  assign bus.sv   = s1_v_q;
  assign bus.slip = s1_slip_q;
  assign bus.ferr = ferr_q;
  assign bus.terr = terr_q;
  assign bus.ovf  = ovf_q;
  assign bus.ev   = ev_q;

endmodule

// File: tb/tb_sym_err_det.sv
// Bench for sym_err_det: two configurations fed the same stream, checked against an integer model.
module tb_sym_err_det;
  localparam int unsigned W   = 8;
  localparam int unsigned AWA = 24;
  localparam int unsigned NLA = 2;
  localparam int unsigned AWB = 18;
  localparam int unsigned NLB = 4;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sym_err_det_if #(.W(W), .AW(AWA)) bus_a ();
  sym_err_det_if #(.W(W), .AW(AWB)) bus_b ();

  sym_err_det #(.W(W), .AW(AWA), .NSYM_LOG2(NLA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  sym_err_det #(.W(W), .AW(AWB), .NSYM_LOG2(NLB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;
  int edge_k = 0;

  // expected per-edge events
  bit     e_sv[MAXE];
  bit     e_slip[MAXE];
  bit     e_rst[MAXE];
  int     e_dx[MAXE];
  int     e_dy[MAXE];
  bit     e_ev[2][MAXE];
  longint e_f[2][MAXE];
  longint e_t[2][MAXE];
  bit     e_o[2][MAXE];

  // model state
  int     m_seen, m_gap, hx2, hy2, hx1, hy1;
  longint acc_f[2], acc_t[2];
  bit     acc_o[2];
  int     nsym[2];
  int     aw_of[2] = '{AWA, AWB};
  int     nl_of[2] = '{NLA, NLB};

  // held expected outputs
  int     h_dx, h_dy;
  longint h_f[2], h_t[2];
  bit     h_o[2];

  // observed event counts / captures for directed checks
  int     sv_cnt, slip_cnt, ev_a, ev_b;
  longint cap_fa, cap_ta, cap_fb;
  int     cap_oa, cap_ob;

  task automatic cmp(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %0d expected %0d", name, edge_k, act, exp);
    end
  endtask

  function automatic longint clampv(input longint v, input int aw, output bit hit);
    longint mx, mn;
    mx = (longint'(1) << (aw - 1)) - 1;
    mn = -(longint'(1) << (aw - 1));
    hit = 1'b0;
    if (v > mx) begin hit = 1'b1; return mx; end
    if (v < mn) begin hit = 1'b1; return mn; end
    return v;
  endfunction

  task automatic model(input int k, input int x, input int y, input bit iv, input bit fv, input bit r);
    longint te, fe;
    bit valid, h1, h2;
    if (r) begin
      e_rst[k] = 1'b1;
      for (int m = 0; m < 2; m++) begin
        e_ev[m][k] = 1'b0; e_ev[m][k+1] = 1'b0;
        nsym[m] = 0; acc_f[m] = 0; acc_t[m] = 0; acc_o[m] = 1'b0;
      end
      m_seen = 0; m_gap = 0; hx2 = 0; hy2 = 0; hx1 = 0; hy1 = 0;
      return;
    end
    if (!iv) return;
    if (!fv) begin
      hx1 = x; hy1 = y;
      if (m_gap < 2) m_gap++;
      return;
    end
    valid = (m_seen != 0) && (m_gap == 1);
    if (m_seen != 0 && !valid) e_slip[k] = 1'b1;
    if (valid) begin
      te = longint'(hx2 - x) * hx1 + longint'(hy2 - y) * hy1;
`ifdef SYM_ERR_QPSK_EN
      fe = ((x >= 0) ? y : -y) - ((y >= 0) ? x : -x);
`else
      fe = longint'(x) * y;
`endif
      e_sv[k] = 1'b1; e_dx[k] = x; e_dy[k] = y;
      for (int m = 0; m < 2; m++) begin
        if (nsym[m] == 0) begin
          acc_f[m] = fe; acc_t[m] = te; acc_o[m] = 1'b0;
        end else begin
          acc_f[m] = acc_f[m] + fe; acc_t[m] = acc_t[m] + te;
        end
        acc_f[m] = clampv(acc_f[m], aw_of[m], h1);
        acc_t[m] = clampv(acc_t[m], aw_of[m], h2);
        acc_o[m] = acc_o[m] | h1 | h2;
        nsym[m]++;
        if (nsym[m] == (1 << nl_of[m])) begin
          e_ev[m][k+2] = 1'b1; e_f[m][k+2] = acc_f[m];
          e_t[m][k+2] = acc_t[m]; e_o[m][k+2] = acc_o[m];
          nsym[m] = 0;
        end
      end
    end
    hx2 = x; hy2 = y; m_gap = 0; m_seen = 1;
  endtask

  task automatic check(input int k);
    if (e_rst[k]) begin
      h_dx = 0; h_dy = 0;
      for (int m = 0; m < 2; m++) begin h_f[m] = 0; h_t[m] = 0; h_o[m] = 1'b0; end
    end
    if (e_sv[k]) begin h_dx = e_dx[k]; h_dy = e_dy[k]; end
    for (int m = 0; m < 2; m++)
      if (e_ev[m][k]) begin h_f[m] = e_f[m][k]; h_t[m] = e_t[m][k]; h_o[m] = e_o[m][k]; end
    cmp("a.sv",   bus_a.sv,   e_sv[k]);
    cmp("a.slip", bus_a.slip, e_slip[k]);
    cmp("a.dox",  int'($signed(bus_a.dox)), h_dx);
    cmp("a.doy",  int'($signed(bus_a.doy)), h_dy);
    cmp("a.ev",   bus_a.ev,   e_ev[0][k]);
    cmp("a.ferr", longint'($signed(bus_a.ferr)), h_f[0]);
    cmp("a.terr", longint'($signed(bus_a.terr)), h_t[0]);
    cmp("a.ovf",  bus_a.ovf,  h_o[0]);
    cmp("b.sv",   bus_b.sv,   e_sv[k]);
    cmp("b.slip", bus_b.slip, e_slip[k]);
    cmp("b.dox",  int'($signed(bus_b.dox)), h_dx);
    cmp("b.ev",   bus_b.ev,   e_ev[1][k]);
    cmp("b.ferr", longint'($signed(bus_b.ferr)), h_f[1]);
    cmp("b.terr", longint'($signed(bus_b.terr)), h_t[1]);
    cmp("b.ovf",  bus_b.ovf,  h_o[1]);
    if (bus_a.sv)   sv_cnt++;
    if (bus_a.slip) slip_cnt++;
    if (bus_a.ev) begin
      ev_a++; cap_fa = longint'($signed(bus_a.ferr)); cap_ta = longint'($signed(bus_a.terr));
      cap_oa = bus_a.ovf;
    end
    if (bus_b.ev) begin
      ev_b++; cap_fb = longint'($signed(bus_b.ferr)); cap_ob = bus_b.ovf;
    end
  endtask

  task automatic step(input int x, input int y, input bit iv, input bit fv, input bit r);
    if (edge_k >= MAXE - 4) begin
      $display("FAIL edge budget exhausted at %0d", edge_k);
      $fatal(1);
    end
    bus_a.dix = x[W-1:0]; bus_a.diy = y[W-1:0]; bus_a.iv = iv; bus_a.fv = fv;
    bus_b.dix = x[W-1:0]; bus_b.diy = y[W-1:0]; bus_b.iv = iv; bus_b.fv = fv;
    rst = r;
    @(posedge clk);
    edge_k++;
    model(edge_k, x, y, iv, fv, r);
    #1;
    check(edge_k);
  endtask

  task automatic clr_cnt();
    sv_cnt = 0; slip_cnt = 0; ev_a = 0; ev_b = 0;
  endtask

  typedef struct {
    string  name;
    int     xa, xb, ma, mb, yon, ymid;
    longint ef, et;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t   vecs[4];
    longint ef_c1, ef_c2, ef_sat;
    int     ov_sat;
`ifdef SYM_ERR_QPSK_EN
    ef_c1 = 0; ef_c2 = 80; ef_sat = 0; ov_sat = 0;
`else
    ef_c1 = 10000; ef_c2 = -6000; ef_sat = 131071; ov_sat = 1;
`endif
    vecs[0] = '{"ideal",   64, -64,  0,   0,  0,   0,   0,     0};
    vecs[1] = '{"late",    64, -64, 32, -32,  0,   0,   0, 16384};
    vecs[2] = '{"carrier", 50,  50, 50,  50, 50,  50, ef_c1,   0};
    vecs[3] = '{"carrier2",50,  50, 50,  50, -30, -30, ef_c2,  0};

    step(0, 0, 0, 0, 1);
    cmp("reset dox", int'(bus_a.dox), 0);
    cmp("reset ev",  bus_a.ev, 0);

    // ---- table-driven steady patterns ----
    for (int v = 0; v < 4; v++) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      clr_cnt();
      for (int i = 0; i < 9; i++) begin
        step((i % 2 == 0) ? vecs[v].xa : vecs[v].xb, vecs[v].yon, 1, 1, 0);
        step((i % 2 == 0) ? vecs[v].ma : vecs[v].mb, vecs[v].ymid, 1, 0, 0);
      end
      repeat (3) step(0, 0, 0, 0, 0);
      cmp({vecs[v].name, " sv count"}, sv_cnt, 8);
      cmp({vecs[v].name, " ev count"}, ev_a, 2);
      cmp({vecs[v].name, " ferr"}, cap_fa, vecs[v].ef);
      cmp({vecs[v].name, " terr"}, cap_ta, vecs[v].et);
      cmp({vecs[v].name, " ovf"}, cap_oa, 0);
    end

    // ---- slip: two consecutive fv mid-block ----
    step(0, 0, 0, 0, 1);
    clr_cnt();
    step(50, 50, 1, 1, 0); step(50, 50, 1, 0, 0);
    step(50, 50, 1, 1, 0); step(50, 50, 1, 0, 0);
    step(50, 50, 1, 1, 0);
    step(50, 50, 1, 1, 0); step(50, 50, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(50, 50, 1, 1, 0); step(50, 50, 1, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0, 0);
    cmp("slip count", slip_cnt, 1);
    cmp("slip sv count", sv_cnt, 5);
    cmp("slip ev count", ev_a, 1);
    cmp("slip ferr", cap_fa, ef_c1);

    // ---- saturation on the 18-bit, 16-symbol instance ----
    step(0, 0, 0, 0, 1);
    clr_cnt();
    for (int i = 0; i < 17; i++) begin
      step(-128, -128, 1, 1, 0); step(-128, -128, 1, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0, 0);
    cmp("sat ev count", ev_b, 1);
    cmp("sat ferr", cap_fb, ef_sat);
    cmp("sat ovf", cap_ob, ov_sat);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0, 0);
    cmp("sat2 ev count", ev_b, 2);
    cmp("sat2 ferr", cap_fb, 0);
    cmp("sat2 ovf", cap_ob, 0);

    // ---- reset in the middle of a block ----
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(50, 50, 1, 1, 0); step(50, 50, 1, 0, 0);
    end
    step(50, 50, 1, 1, 1);
    cmp("rst ferr", longint'($signed(bus_a.ferr)), 0);
    cmp("rst dox", int'($signed(bus_a.dox)), 0);
    cmp("rst sv", bus_a.sv, 0);
    clr_cnt();
    for (int i = 0; i < 4; i++) begin
      step(50, 50, 1, 1, 0); step(50, 50, 1, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0, 0);
    cmp("post-rst no ev", ev_a, 0);
    step(50, 50, 1, 1, 0); step(50, 50, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    cmp("post-rst ev", ev_a, 1);

    // ---- randomized stream against the model ----
    step(0, 0, 0, 0, 1);
    begin
      int ph;
      ph = 0;
      for (int i = 0; i < 3000; i++) begin
        bit ivr, fvr, rr;
        int xr, yr;
        ivr = ($urandom_range(0, 3) != 0);
        rr  = ($urandom_range(0, 499) == 0);
        xr  = int'($urandom_range(0, 255)) - 128;
        yr  = int'($urandom_range(0, 255)) - 128;
        if ($urandom_range(0, 19) == 0) fvr = $urandom_range(0, 1) != 0;
        else fvr = (ph == 0);
        if (ivr) ph ^= 1;
        step(xr, yr, ivr, fvr, rr);
      end
    end
    repeat (4) step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
